holiday_lights_monitor: RTL and testbench

Passive checker on the 16-bit holiday-light LED bus. It decodes the displayed pattern back into run length and head position, tracks the one-bit rotation steps, and flags malformed patterns and step-timing faults. It sits beside the light controller, taps the same `led` vector, and feeds board status LEDs and simulation scoreboards.

---
 rtl/holiday_lights_pkg.sv | 27 ++
 rtl/holiday_lights_monitor_decode.sv | 28 ++
 rtl/holiday_lights_monitor.sv | 154 +++++++++++++++
 tb/tb_holiday_lights_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/holiday_lights_pkg.sv
// Shared types and helpers for the holiday-light bus monitor.
package holiday_lights_pkg;

    localparam int unsigned LED_W   = 16;
    localparam int unsigned MAX_RUN = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StTrack   = 2'd2,
        StFault   = 2'd3
    } mon_state_e;

    function automatic logic [4:0] popcount16(input logic [LED_W-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < LED_W; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] v);
        return {v[LED_W-2:0], v[LED_W-1]};
    endfunction

endpackage

// File: rtl/holiday_lights_monitor_decode.sv
// Combinational decode of a ring pattern into legality, run length, tail and head.
module ring_run_decode import holiday_lights_pkg::*; #(
    parameter int unsigned MAX_RUN = holiday_lights_pkg::MAX_RUN
) (
    input  logic [LED_W-1:0] vec,
    output logic             legal,
    output logic [4:0]       len,
    output logic [3:0]       tail,
    output logic [3:0]       head
);

    logic [LED_W-1:0] tails;

    // A tail is a lit bit whose circular lower neighbour is dark.
    always_comb begin
        tails = vec & ~rotl1(vec);
        len   = popcount16(vec);
        tail  = '0;
        for (int i = 0; i < LED_W; i++) begin
            if (tails[i]) begin
                tail = 4'(i);
            end
        end
        head  = tail + len[3:0] - 4'd1;
        legal = (len != 5'd0) && (len <= 5'(MAX_RUN)) && (popcount16(tails) == 5'd1);
    end

endmodule

// File: rtl/holiday_lights_monitor.sv
// Passive checker on the LED bus: decodes the run, tracks rotation steps and timing.
module holiday_lights_monitor import holiday_lights_pkg::*; #(
    parameter int unsigned STEP_PERIOD = 100_000_001,
    parameter int unsigned STEP_TOL    = 2,
    parameter int unsigned MAX_RUN     = holiday_lights_pkg::MAX_RUN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] led_in,
    output logic             valid,
    output logic [4:0]       run_len,
    output logic [3:0]       head_pos,
    output logic             step_pulse,
    output logic [15:0]      step_cnt,
    output logic             shape_err,
    output logic             period_err,
    output logic [1:0]       state
);

    localparam logic [31:0] IvlHi = 32'(STEP_PERIOD + STEP_TOL);
    localparam logic [31:0] IvlLo = (STEP_PERIOD > STEP_TOL) ? 32'(STEP_PERIOD - STEP_TOL)
                                                             : 32'd0;

    logic [LED_W-1:0] led_q, led_prev_q;
    logic [4:0]       prev_len_q;
    logic [3:0]       prev_tail_q;
    logic             prev_legal_q;
    mon_state_e       state_q;
    logic             valid_q, step_pulse_q, shape_err_q, period_err_q;
    logic [4:0]       run_len_q;
    logic [3:0]       head_q;
    logic [15:0]      step_cnt_q;
    logic [31:0]      ivl_q;

    logic       cur_legal;
    logic [4:0] cur_len;
    logic [3:0] cur_tail, cur_head;
    logic       cur_zero, changed, is_step, len_change;

    ring_run_decode #(.MAX_RUN(MAX_RUN)) u_decode (
        .vec   (led_q),
        .legal (cur_legal),
        .len   (cur_len),
        .tail  (cur_tail),
        .head  (cur_head)
    );

    // For two legal runs of equal length, tail advancing by one is exactly a rotate-left-1.
    assign cur_zero   = (led_q == '0);
    assign changed    = (led_q != led_prev_q);
    assign is_step    = changed && cur_legal && prev_legal_q && (cur_len == prev_len_q) &&
                        (cur_tail == prev_tail_q + 4'd1);
    assign len_change = changed && cur_legal && (cur_len != prev_len_q);

    // Input pipeline, decoded outputs, FSM, interval counter and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q        <= '0;
            led_prev_q   <= '0;
            prev_len_q   <= '0;
            prev_tail_q  <= '0;
            prev_legal_q <= 1'b0;
            state_q      <= StIdle;
            valid_q      <= 1'b0;
            run_len_q    <= '0;
            head_q       <= '0;
            step_pulse_q <= 1'b0;
            step_cnt_q   <= '0;
            shape_err_q  <= 1'b0;
            period_err_q <= 1'b0;
            ivl_q        <= '0;
        end else begin
            led_q        <= led_in;
            led_prev_q   <= led_q;
            prev_len_q   <= cur_len;
            prev_tail_q  <= cur_tail;
            prev_legal_q <= cur_legal;
            valid_q      <= cur_legal;
            run_len_q    <= cur_len;
            if (cur_legal) begin
                head_q <= cur_head;
            end
            step_pulse_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (!cur_zero) begin
                        if (cur_legal) begin
                            state_q <= StAcquire;
                        end else begin
                            state_q     <= StFault;
                            shape_err_q <= 1'b1;
                        end
                    end
                end
                StAcquire: begin
                    if (cur_zero) begin
                        state_q <= StIdle;
                    end else if (is_step) begin
                        state_q      <= StTrack;
                        step_pulse_q <= 1'b1;
                        step_cnt_q   <= 16'd1;
                        ivl_q        <= 32'd1;
                    end else if (changed && !len_change) begin
                        state_q     <= StFault;
                        shape_err_q <= 1'b1;
                    end
                end
                StTrack: begin
                    if (cur_zero) begin
                        state_q <= StIdle;
                    end else if (is_step) begin
                        step_pulse_q <= 1'b1;
                        step_cnt_q   <= step_cnt_q + 16'd1;
                        ivl_q        <= 32'd1;
                        if (ivl_q < IvlLo || ivl_q > IvlHi) begin
                            period_err_q <= 1'b1;
                        end
                    end else if (len_change) begin
                        state_q <= StAcquire;
                        ivl_q   <= '0;
                    end else if (changed) begin
                        state_q     <= StFault;
                        shape_err_q <= 1'b1;
                    end else begin
                        // Flag an overdue step without waiting for it to arrive.
                        if (ivl_q > IvlHi) begin
                            period_err_q <= 1'b1;
                        end
                        if (ivl_q != '1) begin
                            ivl_q <= ivl_q + 32'd1;
                        end
                    end
                end
                StFault: begin
                    if (cur_zero) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign valid      = valid_q;
    assign run_len    = run_len_q;
    assign head_pos   = head_q;
    assign step_pulse = step_pulse_q;
    assign step_cnt   = step_cnt_q;
    assign shape_err  = shape_err_q;
    assign period_err = period_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_holiday_lights_monitor.sv
// Scoreboard bench: stimulus pushes expected step records, a monitor pops them on step_pulse.
module tb_holiday_lights_monitor;

    localparam int P = 10;
    localparam int T = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] led_in = '0;
    logic        valid, step_pulse, shape_err, period_err;
    logic [4:0]  run_len;
    logic [3:0]  head_pos;
    logic [15:0] step_cnt;
    logic [1:0]  state;

    holiday_lights_monitor #(
        .STEP_PERIOD (P),
        .STEP_TOL    (T),
        .MAX_RUN     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .valid      (valid),
        .run_len    (run_len),
        .head_pos   (head_pos),
        .step_pulse (step_pulse),
        .step_cnt   (step_cnt),
        .shape_err  (shape_err),
        .period_err (period_err),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  head;
        logic [4:0]  len;
        logic [15:0] cnt;
        logic        pe;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_checks = 0;
    int   m_cnt = 0;
    int   m_ivl = 0;
    bit   m_pe = 0;

    function automatic void chk(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endfunction

    // Run of len lit LEDs starting at tail, wrapping around the ring.
    function automatic logic [15:0] mk(input int tail, input int len);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < len; i++) v[4'((tail + i) % 16)] = 1'b1;
        return v;
    endfunction

    // Monitor: every step pulse must match the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && step_pulse) begin
            chk("pulse_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_head", 32'(head_pos), 32'(e.head));
                chk("sb_len", 32'(run_len), 32'(e.len));
                chk("sb_cnt", 32'(step_cnt), 32'(e.cnt));
                chk("sb_period_err", 32'(period_err), 32'(e.pe));
                chk("sb_state", 32'(state), 2);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic hold(input logic [15:0] v, input int n);
        led_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        led_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        m_pe = 0;
    endtask

    task automatic check_zeroed(input string tag);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_run_len"}, 32'(run_len), 0);
        chk({tag, "_head"}, 32'(head_pos), 0);
        chk({tag, "_pulse"}, 32'(step_pulse), 0);
        chk({tag, "_step_cnt"}, 32'(step_cnt), 0);
        chk({tag, "_shape_err"}, 32'(shape_err), 0);
        chk({tag, "_period_err"}, 32'(period_err), 0);
        chk({tag, "_state"}, 32'(state), 0);
    endtask

    task automatic acquire(input int tail, input int len);
        hold(mk(tail, len), 5);
        chk("acq_state", 32'(state), 1);
        chk("acq_valid", 32'(valid), 1);
        chk("acq_len", 32'(run_len), 32'(len));
        chk("acq_head", 32'(head_pos), 32'((tail + len - 1) % 16));
    endtask

    // One rotation step; hold_n cycles is the interval to whatever follows.
    task automatic step_to(input int tail, input int len, input bit first, input int hold_n);
        exp_t e;
        if (first) m_cnt = 1;
        else begin
            m_cnt++;
            if (m_ivl < P - T || m_ivl > P + T) m_pe = 1;
        end
        e.head = 4'((tail + len - 1) % 16);
        e.len  = 5'(len);
        e.cnt  = 16'(m_cnt);
        e.pe   = m_pe;
        sb.push_back(e);
        m_ivl = hold_n;
        hold(mk(tail, len), hold_n);
    endtask

    task automatic run_random();
        int t, l, n;
        t = int'($urandom_range(0, 15));
        l = int'($urandom_range(1, 8));
        n = int'($urandom_range(3, 8));
        acquire(t, l);
        for (int s = 1; s <= n; s++) step_to(t + s, l, s == 1, int'($urandom_range(P - T, P + T)));
        chk("rnd_state", 32'(state), 2);
        chk("rnd_step_cnt", 32'(step_cnt), 32'(n));
        chk("rnd_head", 32'(head_pos), 32'((t + n + l - 1) % 16));
        chk("rnd_period_err", 32'(period_err), 32'(m_pe));
        chk("rnd_shape_err", 32'(shape_err), 0);
        hold('0, 3);
        chk("rnd_idle", 32'(state), 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        repeat (3) @(negedge clk);
        check_zeroed("reset");

        // 0x0007 rotated 20 times at the nominal period, across the wrap.
        acquire(0, 3);
        for (int s = 1; s <= 20; s++) step_to(s, 3, s == 1, P);
        chk("run20_step_cnt", 32'(step_cnt), 20);
        chk("run20_head", 32'(head_pos), 6);
        chk("run20_state", 32'(state), 2);
        chk("run20_errs", 32'({shape_err, period_err}), 0);
        hold('0, 3);

        for (int r = 0; r < 4; r++) run_random();

        // Wrapped run 0x8001 then 0x0003.
        acquire(15, 2);
        step_to(0, 2, 1, 5);
        chk("wrap_state", 32'(state), 2);
        hold('0, 3);

        // Early step: pulse and period_err on the same cycle, stays in TRACK.
        do_reset();
        acquire(0, 4);
        step_to(1, 4, 1, 8);
        step_to(2, 4, 0, 3);
        chk("early_state", 32'(state), 2);
        chk("early_period_err", 32'(period_err), 1);

        // Late step after 14 cycles, then reset while tracking.
        do_reset();
        acquire(0, 4);
        step_to(1, 4, 1, 14);
        step_to(2, 4, 0, 3);
        chk("late_state", 32'(state), 2);
        chk("late_period_err", 32'(period_err), 1);
        chk("late_shape_err", 32'(shape_err), 0);
        rst = 1'b1;
        @(negedge clk);
        check_zeroed("rst_track");
        led_in = '0;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        m_pe = 0;

        // Non-rotation jump in TRACK, then back to idle; shape_err is sticky.
        acquire(4, 4);
        step_to(5, 4, 1, P);
        hold(16'h0F00, 3);
        chk("jump_state", 32'(state), 3);
        chk("jump_shape_err", 32'(shape_err), 1);
        hold('0, 3);
        chk("jump_idle", 32'(state), 0);
        chk("jump_sticky", 32'(shape_err), 1);

        // Switch change re-locks without error and the next step restarts the count.
        do_reset();
        acquire(0, 2);
        step_to(1, 2, 1, P);
        hold(16'h001F, 3);
        chk("relock_state", 32'(state), 1);
        chk("relock_len", 32'(run_len), 5);
        chk("relock_errs", 32'({shape_err, period_err}), 0);
        step_to(1, 5, 1, 3);
        chk("relock_track", 32'(state), 2);
        hold('0, 3);

        // Illegal patterns seen from IDLE.
        do_reset();
        hold(16'h0505, 3);
        chk("split_state", 32'(state), 3);
        chk("split_shape_err", 32'(shape_err), 1);
        chk("split_valid", 32'(valid), 0);
        hold('0, 3);
        do_reset();
        hold(16'h01FF, 3);
        chk("long_state", 32'(state), 3);
        chk("long_valid", 32'(valid), 0);
        chk("long_run_len", 32'(run_len), 9);
        chk("long_head_hold", 32'(head_pos), 0);
        hold('0, 3);

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
